// File: rtl/mem_align_pkg.sv
// Shared types for the memory access aligner: FSM states, scalar size encoding
// and the size-to-byte-count helper.
package mem_align_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWr0,
        StWr1,
        StRd0,
        StRd1,
        StRd2,
        StResp
    } state_e;

    typedef enum logic [1:0] {
        Size1B   = 2'd0,
        Size2B   = 2'd1,
        Size4B   = 2'd2,
        SizeRsvd = 2'd3
    } size_e;

    // Reserved encoding behaves as a 4-byte access.
    function automatic logic [3:0] size_to_nbytes(input size_e size);
        case (size)
            Size1B:  return 4'd1;
            Size2B:  return 4'd2;
            default: return 4'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_align_shifter.sv
// Byte-lane shifter shared by both paths: places write data and byte enables across a
// two-line window, and extracts read data from a two-line window.
module mem_align_shifter #(
    parameter int unsigned LINE_BYTES = 32
) (
    input  logic [$clog2(LINE_BYTES)-1:0] off,
    input  logic [$clog2(LINE_BYTES):0]   nbytes,
    input  logic [8*LINE_BYTES-1:0]       wr_data,
    input  logic [16*LINE_BYTES-1:0]      rd_lines,
    output logic [16*LINE_BYTES-1:0]      wr_lanes,
    output logic [2*LINE_BYTES-1:0]       wr_be,
    output logic [8*LINE_BYTES-1:0]       rd_data
);

    localparam int unsigned DW = 8 * LINE_BYTES;

    logic [2*LINE_BYTES-1:0] be_base;
    logic [2*DW-1:0]         rd_shift;
    logic                    unused_rd_hi;

    always_comb begin
        be_base = '0;
        for (int i = 0; i < int'(2 * LINE_BYTES); i++) begin
            be_base[i] = (i < int'(nbytes));
        end
        wr_lanes = {{DW{1'b0}}, wr_data} << {off, 3'b000};
        wr_be    = be_base << off;
        rd_shift = rd_lines >> {off, 3'b000};
        rd_data  = rd_shift[DW-1:0];
    end

    assign unused_rd_hi = ^rd_shift[2*DW-1:DW];

endmodule

// File: rtl/mem_access_aligner.sv
// Splits unaligned scalar/vector accesses into one or two RAM line accesses.
// Define MEM_ALIGN_SIGNEXT_EN to sign-extend scalar loads when req_signed is set.
module mem_access_aligner
    import mem_align_pkg::*;
#(
    parameter int unsigned LINE_BYTES = 32,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned RAM_AW     = 14
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic                    req_vec,
    input  logic [1:0]              req_size,
    input  logic                    req_signed,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [31:0]             req_wdata_s,
    input  logic [8*LINE_BYTES-1:0] req_wdata_v,
    output logic                    resp_valid,
    output logic [31:0]             resp_rdata_s,
    output logic [8*LINE_BYTES-1:0] resp_rdata_v,
    output logic                    busy,
    output logic                    mem_rden,
    output logic                    mem_wren,
    output logic [RAM_AW-1:0]       mem_addr,
    output logic [LINE_BYTES-1:0]   mem_byteena,
    output logic [8*LINE_BYTES-1:0] mem_wdata,
    input  logic [8*LINE_BYTES-1:0] mem_rdata
);

    localparam int unsigned OW = $clog2(LINE_BYTES);
    localparam int unsigned DW = 8 * LINE_BYTES;

    state_e                 state_q, state_d;
    logic                   we_q, vec_q, signed_q;
    size_e                  size_q;
    logic [OW-1:0]          off_q;
    logic [RAM_AW-1:0]      line_q, addr_hold_q;
    logic [DW-1:0]          data_q, line0_q, line1_q, wdata_hold_q, rdata_v_q;
    logic [31:0]            rdata_s_q;
    logic [OW:0]            nbytes;
    logic                   span;
    logic [2*DW-1:0]        wr_lanes;
    logic [2*LINE_BYTES-1:0] wr_be;
    logic [DW-1:0]          rd_v;
    logic [31:0]            rd_raw, rd_s;
    logic                   unused_in;

    assign nbytes = vec_q ? (OW+1)'(LINE_BYTES) : (OW+1)'(size_to_nbytes(size_q));
    assign span   = ({1'b0, off_q} + nbytes) > (OW+1)'(LINE_BYTES);

    mem_align_shifter #(
        .LINE_BYTES(LINE_BYTES)
    ) u_shifter (
        .off      (off_q),
        .nbytes   (nbytes),
        .wr_data  (data_q),
        .rd_lines ({line1_q, line0_q}),
        .wr_lanes (wr_lanes),
        .wr_be    (wr_be),
        .rd_data  (rd_v)
    );

    assign rd_raw = rd_v[31:0];

    always_comb begin
        case (size_q)
            Size1B:  rd_s = {24'd0, rd_raw[7:0]};
            Size2B:  rd_s = {16'd0, rd_raw[15:0]};
            default: rd_s = rd_raw;
        endcase
`ifdef MEM_ALIGN_SIGNEXT_EN
        if (signed_q) begin
            case (size_q)
                Size1B:  rd_s = {{24{rd_raw[7]}}, rd_raw[7:0]};
                Size2B:  rd_s = {{16{rd_raw[15]}}, rd_raw[15:0]};
                default: rd_s = rd_raw;
            endcase
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (req_valid) state_d = req_we ? StWr0 : StRd0;
            StWr0:   state_d = span ? StWr1 : StResp;
            StWr1:   state_d = StResp;
            StRd0:   state_d = StRd1;
            StRd1:   state_d = span ? StRd2 : StResp;
            StRd2:   state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready    = 1'b0;
        busy         = 1'b1;
        resp_valid   = 1'b0;
        mem_rden     = 1'b0;
        mem_wren     = 1'b0;
        mem_byteena  = '0;
        mem_addr     = addr_hold_q;
        mem_wdata    = wdata_hold_q;
        resp_rdata_s = rdata_s_q;
        resp_rdata_v = rdata_v_q;
        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                busy      = 1'b0;
            end
            StWr0: begin
                mem_wren    = 1'b1;
                mem_addr    = line_q;
                mem_wdata   = wr_lanes[DW-1:0];
                mem_byteena = wr_be[LINE_BYTES-1:0];
            end
            StWr1: begin
                mem_wren    = 1'b1;
                mem_addr    = line_q + 1'b1;
                mem_wdata   = wr_lanes[2*DW-1:DW];
                mem_byteena = wr_be[2*LINE_BYTES-1:LINE_BYTES];
            end
            StRd0: begin
                mem_rden = 1'b1;
                mem_addr = line_q;
            end
            StRd1: begin
                if (span) begin
                    mem_rden = 1'b1;
                    mem_addr = line_q + 1'b1;
                end
            end
            StResp: begin
                resp_valid = 1'b1;
                if (!we_q) begin
                    resp_rdata_s = rd_s;
                    resp_rdata_v = rd_v;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            we_q         <= 1'b0;
            vec_q        <= 1'b0;
            signed_q     <= 1'b0;
            size_q       <= Size1B;
            off_q        <= '0;
            line_q       <= '0;
            data_q       <= '0;
            line0_q      <= '0;
            line1_q      <= '0;
            addr_hold_q  <= '0;
            wdata_hold_q <= '0;
            rdata_s_q    <= '0;
            rdata_v_q    <= '0;
        end else begin
            if (req_valid && req_ready) begin
                we_q     <= req_we;
                vec_q    <= req_vec;
                signed_q <= req_signed;
                size_q   <= size_e'(req_size);
                off_q    <= req_addr[OW-1:0];
                line_q   <= req_addr[OW+RAM_AW-1:OW];
                data_q   <= req_vec ? req_wdata_v : {{(DW-32){1'b0}}, req_wdata_s};
            end
            // Non-spanning reads see zeros in the upper line of the window.
            if (state_q == StRd1) begin
                line0_q <= mem_rdata;
                if (!span) line1_q <= '0;
            end
            if (state_q == StRd2) line1_q <= mem_rdata;
            addr_hold_q  <= mem_addr;
            wdata_hold_q <= mem_wdata;
            if (state_q == StResp && !we_q) begin
                rdata_s_q <= rd_s;
                rdata_v_q <= rd_v;
            end
        end
    end

    assign unused_in = ^{req_addr, signed_q};

endmodule

// File: tb/tb_mem_access_aligner.sv
// Directed self-checking bench for mem_access_aligner with a byte-enabled RAM model.
module tb_mem_access_aligner;

    localparam int unsigned LB = 32;
    localparam int unsigned DW = 8 * LB;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic          req_vec = 1'b0;
    logic [1:0]    req_size = 2'd0;
    logic          req_signed = 1'b0;
    logic [31:0]   req_addr = '0;
    logic [31:0]   req_wdata_s = '0;
    logic [DW-1:0] req_wdata_v = '0;
    logic          resp_valid;
    logic [31:0]   resp_rdata_s;
    logic [DW-1:0] resp_rdata_v;
    logic          busy;
    logic          mem_rden;
    logic          mem_wren;
    logic [13:0]   mem_addr;
    logic [LB-1:0] mem_byteena;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    always #5 clk = ~clk;

    mem_access_aligner #(
        .LINE_BYTES(32),
        .ADDR_W(32),
        .RAM_AW(14)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_vec      (req_vec),
        .req_size     (req_size),
        .req_signed   (req_signed),
        .req_addr     (req_addr),
        .req_wdata_s  (req_wdata_s),
        .req_wdata_v  (req_wdata_v),
        .resp_valid   (resp_valid),
        .resp_rdata_s (resp_rdata_s),
        .resp_rdata_v (resp_rdata_v),
        .busy         (busy),
        .mem_rden     (mem_rden),
        .mem_wren     (mem_wren),
        .mem_addr     (mem_addr),
        .mem_byteena  (mem_byteena),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    // RAM model with a bench-side preload port.
    logic [DW-1:0] ram [0:16383];
    logic          pl_en = 1'b0;
    logic [13:0]   pl_addr = '0;
    logic [DW-1:0] pl_data = '0;

    always @(posedge clk) begin
        if (pl_en) ram[pl_addr] <= pl_data;
        if (mem_rden) mem_rdata <= ram[mem_addr];
        if (mem_wren) begin
            for (int b = 0; b < int'(LB); b++) begin
                if (mem_byteena[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    int            lat;
    int            wr_n;
    int            rd_n;
    logic [13:0]   wr_addr [4];
    logic [31:0]   wr_be   [4];
    logic [DW-1:0] wr_dat  [4];
    logic [31:0]   got_s;
    logic [DW-1:0] got_v;
    logic [DW-1:0] pat;
    int            seen;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [13:0] line, input logic [DW-1:0] data);
        @(negedge clk);
        pl_en   = 1'b1;
        pl_addr = line;
        pl_data = data;
        @(negedge clk);
        pl_en   = 1'b0;
    endtask

    // Issue one request and log RAM strobes until resp_valid or a 10-cycle budget.
    task automatic do_req(input logic we, input logic vec, input logic [1:0] size,
                          input logic sgn, input logic [31:0] addr,
                          input logic [31:0] ws, input logic [DW-1:0] wv);
        @(negedge clk);
        req_we      = we;
        req_vec     = vec;
        req_size    = size;
        req_signed  = sgn;
        req_addr    = addr;
        req_wdata_s = ws;
        req_wdata_v = wv;
        req_valid   = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat  = 0;
        wr_n = 0;
        rd_n = 0;
        for (int c = 1; c <= 10 && lat == 0; c++) begin
            @(negedge clk);
            if (mem_wren && wr_n < 4) begin
                wr_addr[wr_n] = mem_addr;
                wr_be[wr_n]   = mem_byteena;
                wr_dat[wr_n]  = mem_wdata;
                wr_n++;
            end
            if (mem_rden) rd_n++;
            if (resp_valid) begin
                lat   = c;
                got_s = resp_rdata_s;
                got_v = resp_rdata_v;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < int'(LB); i++) pat[8*i +: 8] = 8'(i + 1);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_rden_wren", {mem_rden, mem_wren}, 0);
        check("rst_byteena", mem_byteena, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_rdata_s", resp_rdata_s, 0);
        check("rst_rdata_v", resp_rdata_v, 0);
        reset = 1'b0;

        // Aligned vector write: single access.
        do_req(1'b1, 1'b1, 2'd0, 1'b0, 32'h40, 32'h0, pat);
        check("vw_al_lat", lat, 2);
        check("vw_al_nwr", wr_n, 1);
        check("vw_al_addr", wr_addr[0], 14'd2);
        check("vw_al_be", wr_be[0], 32'hFFFF_FFFF);
        check("vw_al_data", wr_dat[0], pat);
        @(negedge clk);
        check("idle_addr_hold", mem_addr, 14'd2);
        check("idle_wdata_hold", mem_wdata, pat);
        check("idle_be_zero", mem_byteena, 0);
        check("idle_wren_zero", mem_wren, 0);

        // Unaligned vector write: two accesses.
        do_req(1'b1, 1'b1, 2'd0, 1'b0, 32'h50, 32'h0, pat);
        check("vw_sp_lat", lat, 3);
        check("vw_sp_nwr", wr_n, 2);
        check("vw_sp_addr0", wr_addr[0], 14'd2);
        check("vw_sp_be0", wr_be[0], 32'hFFFF_0000);
        check("vw_sp_data0", wr_dat[0], pat << 128);
        check("vw_sp_addr1", wr_addr[1], 14'd3);
        check("vw_sp_be1", wr_be[1], 32'h0000_FFFF);
        check("vw_sp_data1", wr_dat[1], pat >> 128);

        // Read the unaligned vector back through the span path.
        do_req(1'b0, 1'b1, 2'd0, 1'b0, 32'h50, 32'h0, '0);
        check("vr_sp_lat", lat, 4);
        check("vr_sp_nrd", rd_n, 2);
        check("vr_sp_data", got_v, pat);

        // Spanning 4B scalar read.
        preload(14'd1, {16'h7856, 240'h0});
        preload(14'd2, 256'h3412);
        do_req(1'b0, 1'b0, 2'd2, 1'b0, 32'h3E, 32'h0, '0);
        check("sr4_sp_lat", lat, 4);
        check("sr4_sp_data", got_s, 32'h3412_7856);

        // Non-spanning 2B and 1B scalar reads from line 1.
        preload(14'd1, {200'h0, 8'h80, 8'h00, 8'hAB, 8'hCD, 16'h0});
        do_req(1'b0, 1'b0, 2'd1, 1'b0, 32'h22, 32'h0, '0);
        check("sr2_lat", lat, 3);
        check("sr2_nrd", rd_n, 1);
        check("sr2_data", got_s, 32'h0000_ABCD);
        do_req(1'b0, 1'b0, 2'd0, 1'b1, 32'h25, 32'h0, '0);
`ifdef MEM_ALIGN_SIGNEXT_EN
        check("sr1_signed", got_s, 32'hFFFF_FF80);
`else
        check("sr1_signed", got_s, 32'h0000_0080);
`endif
        do_req(1'b0, 1'b0, 2'd0, 1'b0, 32'h25, 32'h0, '0);
        check("sr1_unsigned", got_s, 32'h0000_0080);

        // Scalar writes; read results must be left untouched.
        do_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h104, 32'hDEAD_BEEF, '0);
        check("sw4_lat", lat, 2);
        check("sw4_addr", wr_addr[0], 14'd8);
        check("sw4_be", wr_be[0], 32'h0000_00F0);
        check("sw4_data", wr_dat[0], 256'hDEAD_BEEF << 32);
        check("sw_rdata_hold", got_s, 32'h0000_0080);
        do_req(1'b1, 1'b0, 2'd1, 1'b0, 32'h11F, 32'hDEAD_BEEF, '0);
        check("sw2_sp_lat", lat, 3);
        check("sw2_sp_be0", wr_be[0], 32'h8000_0000);
        check("sw2_sp_data0", wr_dat[0], 256'hEF << 248);
        check("sw2_sp_addr1", wr_addr[1], 14'd9);
        check("sw2_sp_be1", wr_be[1], 32'h0000_0001);
        check("sw2_sp_data1", wr_dat[1], 256'h00DE_ADBE);
        do_req(1'b0, 1'b0, 2'd1, 1'b0, 32'h11F, 32'h0, '0);
        check("sr2_sp_data", got_s, 32'h0000_BEEF);

        // Line address wraps from the top line to line 0.
        do_req(1'b1, 1'b1, 2'd0, 1'b0, 32'h7FFF0, 32'h0, pat);
        check("wrap_addr0", wr_addr[0], 14'h3FFF);
        check("wrap_addr1", wr_addr[1], 14'h0000);

        // Reset in the middle of a spanning read.
        @(negedge clk);
        req_we    = 1'b0;
        req_vec   = 1'b1;
        req_addr  = 32'h50;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("mid_busy", busy, 1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("mid_rst_ready", req_ready, 1);
        check("mid_rst_busy", busy, 0);
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (resp_valid || mem_rden || mem_wren) seen++;
            @(negedge clk);
        end
        check("mid_rst_quiet", seen, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
